seq_bcd_converter: RTL and testbench

- Sequential, parametrised binary-to-BCD converter: the multi-cycle successor to the combinational 16-bit double-dabble stage.
- Sits between the multiplier product and the bidirectional BCD shift register.
- Supports any WIDTH and DIGITS, signed or unsigned input selected per conversion, and a start/busy/done handshake.
- Uses one add-3/shift iteration per clock, trading latency for area.

---
 rtl/seq_bcd_converter.sv | 184 ++++++++++++++++++
 tb/tb_seq_bcd_converter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bcd_converter.sv
// -----------------------------------------------------------------------------
// seq_bcd_converter
// Sequential binary-to-BCD converter (double dabble, one add-3/shift per clock).
// A conversion is accepted from IDLE on start. It then runs WIDTH shift
// iterations and publishes the result, so done pulses WIDTH+1 edges after the
// accepting edge. bcd and is_negative only change at publish.
//
// Parameters:
//   WIDTH       binary input width (>= 2)
//   DIGITS      number of BCD output digits (output width 4*DIGITS)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        conversion request, sampled only while idle
//   bin          binary operand, captured on the accepting edge
//   signed_mode  1 = bin is two's complement, captured with bin
//   busy         conversion in progress
//   done         one-cycle pulse, new result valid
//   bcd          packed BCD magnitude, digit 0 in bits [3:0]
//   is_negative  sign of the last published result
//   ovf          (only with SEQ_BCD_OVF_DETECT_EN) magnitude did not fit
//                in DIGITS digits
//
// Optional feature macro: SEQ_BCD_OVF_DETECT_EN
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start, outputs hold last published result
// S_SHIFT   | one add-3 / shift iteration per clock, WIDTH iterations
// S_PUBLISH | copy accumulator and sign to the outputs, pulse done
// -----------------------------------------------------------------------------
module seq_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    input  logic                signed_mode,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                is_negative
`ifdef SEQ_BCD_OVF_DETECT_EN
    ,
    output logic                ovf
`endif
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_mag;
    logic [4*DIGITS-1:0] r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_sign;
    logic                r_busy;
    logic                r_done;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_neg;
`ifdef SEQ_BCD_OVF_DETECT_EN
    logic                r_ovf_sticky;
    logic                r_ovf;
    logic                w_shift_out;
`endif

    logic [WIDTH-1:0]    w_mag_in;
    logic [3:0]          w_top;
    logic [4*DIGITS-2:0] w_adj;
    logic [4*DIGITS-1:0] w_acc_next;

    // The most negative input negates to 2^(WIDTH-1), which still fits
    // in WIDTH unsigned bits.
    assign w_mag_in = (signed_mode && bin[WIDTH-1]) ? (~bin + BIN_ONE) : bin;

    assign w_top = r_acc[4*DIGITS-1 -: 4];

    // Only the low three bits of the adjusted top digit survive the shift.
    // Its MSB is the bit that falls off the end. Since a valid digit is at
    // most 9, that MSB is 1 exactly when the digit is >= 5.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4];
            end
        end
        if (w_top >= 4'd5) begin
            w_adj[4*DIGITS-2 -: 3] = w_top[2:0] + 3'd3;
        end else begin
            w_adj[4*DIGITS-2 -: 3] = w_top[2:0];
        end
    end

    assign w_acc_next = {w_adj, r_mag[WIDTH-1]};

`ifdef SEQ_BCD_OVF_DETECT_EN
    assign w_shift_out = (w_top >= 4'd5);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mag        <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_sign       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bcd        <= '0;
            r_neg        <= 1'b0;
`ifdef SEQ_BCD_OVF_DETECT_EN
            r_ovf_sticky <= 1'b0;
            r_ovf        <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mag   <= w_mag_in;
                        r_sign  <= signed_mode & bin[WIDTH-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
`ifdef SEQ_BCD_OVF_DETECT_EN
                        r_ovf_sticky <= 1'b0;
                        r_ovf        <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CNT_ONE;
`ifdef SEQ_BCD_OVF_DETECT_EN
                    if (w_shift_out) begin
                        r_ovf_sticky <= 1'b1;
                    end
`endif
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    r_bcd   <= r_acc;
                    r_neg   <= r_sign;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef SEQ_BCD_OVF_DETECT_EN
                    r_ovf   <= r_ovf_sticky;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign bcd         = r_bcd;
    assign is_negative = r_neg;
`ifdef SEQ_BCD_OVF_DETECT_EN
    assign ovf         = r_ovf;
`endif

endmodule

// File: tb/tb_seq_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_seq_bcd_converter
// Self-checking bench for seq_bcd_converter. Three instances are used:
//   u_dut8  WIDTH=8,  DIGITS=3
//   u_dut16 WIDTH=16, DIGITS=5
//   u_dut2  WIDTH=8,  DIGITS=2 (truncating)
// Expected results come from plain arithmetic: the magnitude is taken, reduced
// modulo 10^DIGITS, and split into decimal digits.
// Honours SEQ_BCD_OVF_DETECT_EN for the optional ovf port.
// -----------------------------------------------------------------------------
module tb_seq_bcd_converter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s8_start = 1'b0, s8_sm = 1'b0;
    logic [7:0]  s8_bin = '0;
    logic        s8_busy, s8_done, s8_neg;
    logic [11:0] s8_bcd;

    logic        s16_start = 1'b0, s16_sm = 1'b0;
    logic [15:0] s16_bin = '0;
    logic        s16_busy, s16_done, s16_neg;
    logic [19:0] s16_bcd;

    logic        s2_start = 1'b0, s2_sm = 1'b0;
    logic [7:0]  s2_bin = '0;
    logic        s2_busy, s2_done, s2_neg;
    logic [7:0]  s2_bcd;

`ifdef SEQ_BCD_OVF_DETECT_EN
    logic s8_ovf, s16_ovf, s2_ovf;
`endif

    seq_bcd_converter #(.WIDTH(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .bin(s8_bin),
        .signed_mode(s8_sm), .busy(s8_busy), .done(s8_done), .bcd(s8_bcd),
        .is_negative(s8_neg)
`ifdef SEQ_BCD_OVF_DETECT_EN
        , .ovf(s8_ovf)
`endif
    );

    seq_bcd_converter #(.WIDTH(16), .DIGITS(5)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16_start), .bin(s16_bin),
        .signed_mode(s16_sm), .busy(s16_busy), .done(s16_done), .bcd(s16_bcd),
        .is_negative(s16_neg)
`ifdef SEQ_BCD_OVF_DETECT_EN
        , .ovf(s16_ovf)
`endif
    );

    seq_bcd_converter #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .bin(s2_bin),
        .signed_mode(s2_sm), .busy(s2_busy), .done(s2_done), .bcd(s2_bcd),
        .is_negative(s2_neg)
`ifdef SEQ_BCD_OVF_DETECT_EN
        , .ovf(s2_ovf)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mag(input logic [31:0] b, input int w, input bit sm);
        if (sm && b[w-1]) return (32'd1 << w) - b;
        return b;
    endfunction

    function automatic logic [31:0] ref_bcd(input logic [31:0] mag, input int digits);
        logic [31:0] r = '0;
        logic [31:0] m = mag;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] pow10(input int digits);
        logic [31:0] p = 32'd1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p;
    endfunction

    // Called #1 after the accepting edge; lat counts edges until done is seen.
    task automatic wait8(output int lat, output int bsy, output int herr);
        logic [11:0] prev;
        prev = s8_bcd;
        lat = 0; bsy = 0; herr = 0;
        while (!s8_done && lat < 40) begin
            if (s8_busy) bsy++;
            if (s8_bcd !== prev) herr++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (!s16_done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait2(output int lat);
        lat = 0;
        while (!s2_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] b, input bit sm);
        int lat, bsy, herr;
        logic [31:0] m;
        m = ref_mag(32'(b), 8, sm);
        @(posedge clk); #1;
        s8_bin = b; s8_sm = sm; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0; s8_bin = 8'($urandom); s8_sm = 1'($urandom);
        wait8(lat, bsy, herr);
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_busy_cycles"}, 32'(bsy), 32'd9);
        check({tag, "_hold"}, 32'(herr), 32'd0);
        check({tag, "_busy_at_done"}, 32'(s8_busy), 32'd0);
        check({tag, "_bcd"}, 32'(s8_bcd), ref_bcd(m, 3));
        check({tag, "_neg"}, 32'(s8_neg), 32'(sm && b[7]));
`ifdef SEQ_BCD_OVF_DETECT_EN
        check({tag, "_ovf"}, 32'(s8_ovf), 32'(m >= pow10(3)));
`endif
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(s8_done), 32'd0);
    endtask

    task automatic run16(input string tag, input logic [15:0] b, input bit sm);
        int lat;
        logic [31:0] m;
        m = ref_mag(32'(b), 16, sm);
        @(posedge clk); #1;
        s16_bin = b; s16_sm = sm; s16_start = 1'b1;
        @(posedge clk); #1;
        s16_start = 1'b0; s16_bin = 16'($urandom); s16_sm = 1'($urandom);
        wait16(lat);
        check({tag, "_latency"}, 32'(lat), 32'd17);
        check({tag, "_bcd"}, 32'(s16_bcd), ref_bcd(m, 5));
        check({tag, "_neg"}, 32'(s16_neg), 32'(sm && b[15]));
    endtask

    task automatic run2(input string tag, input logic [7:0] b, input bit sm);
        int lat;
        logic [31:0] m;
        m = ref_mag(32'(b), 8, sm);
        @(posedge clk); #1;
        s2_bin = b; s2_sm = sm; s2_start = 1'b1;
        @(posedge clk); #1;
        s2_start = 1'b0; s2_bin = 8'($urandom); s2_sm = 1'($urandom);
        wait2(lat);
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_bcd"}, 32'(s2_bcd), ref_bcd(m, 2));
        check({tag, "_neg"}, 32'(s2_neg), 32'(sm && b[7]));
`ifdef SEQ_BCD_OVF_DETECT_EN
        check({tag, "_ovf"}, 32'(s2_ovf), 32'(m >= pow10(2)));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, bsy, herr, ndone;

        // Reset values
        #12;
        check("rst_busy", 32'(s8_busy), 32'd0);
        check("rst_done", 32'(s8_done), 32'd0);
        check("rst_bcd", 32'(s8_bcd), 32'd0);
        check("rst_neg", 32'(s8_neg), 32'd0);
`ifdef SEQ_BCD_OVF_DETECT_EN
        check("rst_ovf", 32'(s2_ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run8("neg5", 8'hFB, 1'b1);
        run8("most_neg", 8'h80, 1'b1);
        run8("uns_ff", 8'hFF, 1'b0);
        run8("signed_zero", 8'h00, 1'b1);
        run8("signed_pos", 8'h7F, 1'b1);

        // Randomized against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            run8("rnd8", 8'($urandom), 1'($urandom));
        end

        // start held high through a whole conversion
        @(posedge clk); #1;
        s8_bin = 8'd99; s8_sm = 1'b0; s8_start = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        for (int k = 1; k <= 9; k++) begin
            s8_bin = 8'($urandom); s8_sm = 1'($urandom);
            @(posedge clk); #1;
            if (s8_done) ndone++;
        end
        check("held_start_one_done", 32'(ndone), 32'd1);
        check("held_start_done_now", 32'(s8_done), 32'd1);
        check("held_start_bcd", 32'(s8_bcd), 32'h099);
        // start still high in the done cycle: accepted at the next edge
        s8_bin = 8'd37; s8_sm = 1'b0;
        @(posedge clk); #1;
        s8_start = 1'b0; s8_bin = 8'($urandom); s8_sm = 1'b1;
        wait8(lat, bsy, herr);
        check("held_restart_latency", 32'(lat), 32'd9);
        check("held_restart_bcd", 32'(s8_bcd), 32'h037);

        // Reset in the middle of a conversion
        run8("pre_rst", 8'hF0, 1'b1);
        @(posedge clk); #1;
        s8_bin = 8'd123; s8_sm = 1'b0; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(s8_busy), 32'd0);
        check("midrst_bcd", 32'(s8_bcd), 32'd0);
        check("midrst_neg", 32'(s8_neg), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (s8_done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run8("post_rst", 8'd7, 1'b0);

        // 16-bit back-to-back conversions
        @(posedge clk); #1;
        s16_bin = 16'd50; s16_sm = 1'b0; s16_start = 1'b1;
        @(posedge clk); #1;
        s16_start = 1'b0; s16_bin = 16'($urandom);
        wait16(lat);
        check("b2b_first_latency", 32'(lat), 32'd17);
        check("b2b_first_bcd", 32'(s16_bcd), 32'h00050);
        s16_start = 1'b1; s16_bin = 16'hFFFF; s16_sm = 1'b0;
        @(posedge clk); #1;
        s16_start = 1'b0; s16_sm = 1'b1; s16_bin = 16'($urandom);
        wait16(lat);
        check("b2b_second_latency", 32'(lat), 32'd17);
        check("b2b_second_bcd", 32'(s16_bcd), 32'h65535);
        check("b2b_second_neg", 32'(s16_neg), 32'd0);

        run16("w16_most_neg", 16'h8000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run16("rnd16", 16'($urandom), 1'($urandom));
        end

        // Truncation to two digits
        run2("trunc200", 8'd200, 1'b0);
        run2("after_trunc42", 8'd42, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run2("rnd2", 8'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
